// File: rtl/decode_dispatch_ctrl_pkg.sv
// Shared types, widths and helpers for the decode dispatch controller.
// Bundle width `N and the WFI encoding default here unless the build defines them.
`ifndef N
`define N 2
`endif
`ifndef WFI
`define WFI 32'h1050_0073
`endif

package decode_dispatch_ctrl_pkg;

    localparam int unsigned DISP_N          = `N;
    localparam int unsigned DISP_DEPTH      = 8;
    localparam int unsigned QUEUE_IDX_WIDTH = $clog2(DISP_DEPTH);
    localparam int unsigned COUNT_WIDTH     = $clog2(DISP_N + 1);
    localparam int unsigned OCC_WIDTH       = $clog2(DISP_DEPTH + 1);
    localparam logic [31:0] WFI_INST        = `WFI;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        valid;
    } IF_ID_PACKET;

    typedef enum logic {
        DISP_RUN,
        DISP_HALTED
    } DISPATCH_STATE;

    function automatic logic is_wfi(input IF_ID_PACKET p);
        return p.inst == WFI_INST;
    endfunction

endpackage

// File: rtl/dispatch_inst_queue.sv
// In-order instruction queue: circular buffer with N-wide write and read ports.
// Head/tail wrap modulo DEPTH; fill level is kept in its own counter.
module dispatch_inst_queue
    import decode_dispatch_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = DISP_DEPTH,
    parameter int unsigned N     = DISP_N,
    parameter int unsigned IDX_W = QUEUE_IDX_WIDTH,
    parameter int unsigned OCC_W = OCC_WIDTH,
    parameter int unsigned CNT_W = COUNT_WIDTH
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_clear,
    input  IF_ID_PACKET       i_wr_packet [N],
    input  logic [CNT_W-1:0]  i_enq_cnt,
    input  logic [CNT_W-1:0]  i_deq_cnt,
    output IF_ID_PACKET       o_rd_packet [N],
    output logic [OCC_W-1:0]  o_occupancy
);

    IF_ID_PACKET      r_mem [DEPTH];
    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [OCC_W-1:0] r_occ;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else if (i_clear) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            r_head <= r_head + IDX_W'(i_deq_cnt);
            r_tail <= r_tail + IDX_W'(i_enq_cnt);
            r_occ  <= r_occ + OCC_W'(i_enq_cnt) - OCC_W'(i_deq_cnt);
        end
    end

    // Storage needs no reset: entries beyond the fill level are never presented as valid.
    always_ff @(posedge i_clock) begin
        for (int k = 0; k < int'(N); k++) begin
            if (!i_clear && (k < int'(i_enq_cnt))) begin
                r_mem[r_tail + IDX_W'(k)] <= i_wr_packet[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < int'(N); k++) begin
            o_rd_packet[k] = r_mem[r_head + IDX_W'(k)];
        end
    end

    assign o_occupancy = r_occ;

endmodule

// File: rtl/decode_dispatch_ctrl.sv
// Dispatch controller ahead of decode: queues fetch bundles and releases them limited by
// ROB/RS spots, halts after WFI, flushes on squash. DISPATCH_BYPASS_EN enables same-cycle bypass.
module decode_dispatch_ctrl
    import decode_dispatch_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = DISP_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       squash,
    input  IF_ID_PACKET                if_packet [DISP_N],
    output logic                       if_ready,
    input  logic [COUNT_WIDTH-1:0]     rob_spots,
    input  logic [COUNT_WIDTH-1:0]     rs_spots,
    output IF_ID_PACKET                id_packet [DISP_N],
    output logic [COUNT_WIDTH-1:0]     dispatch_cnt,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       halted
);

    localparam int unsigned N     = DISP_N;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned CNT_W = COUNT_WIDTH;

    DISPATCH_STATE    r_state;
    DISPATCH_STATE    w_state_next;
    IF_ID_PACKET      w_q_packet  [N];
    IF_ID_PACKET      w_src       [N];
    IF_ID_PACKET      w_wr_packet [N];
    logic [OCC_W-1:0] w_occ;
    logic [CNT_W-1:0] w_in_cnt;
    logic [CNT_W-1:0] w_disp_cnt;
    logic [CNT_W-1:0] w_enq_cnt;
    logic [CNT_W-1:0] w_deq_cnt;
    logic             w_accept;
    logic             w_bypass;
    logic             w_wfi_hit;

    dispatch_inst_queue #(
        .DEPTH (DEPTH),
        .N     (N),
        .IDX_W (IDX_W),
        .OCC_W (OCC_W),
        .CNT_W (CNT_W)
    ) u_queue (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_clear     (squash),
        .i_wr_packet (w_wr_packet),
        .i_enq_cnt   (w_enq_cnt),
        .i_deq_cnt   (w_deq_cnt),
        .o_rd_packet (w_q_packet),
        .o_occupancy (w_occ)
    );

    // Valid lanes form a prefix, so a popcount gives the bundle size.
    always_comb begin
        w_in_cnt = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (if_packet[k].valid) begin
                w_in_cnt = w_in_cnt + CNT_W'(1);
            end
        end
    end

    assign w_accept = if_ready && !squash;

`ifdef DISPATCH_BYPASS_EN
    assign w_bypass = w_accept && (r_state == DISP_RUN) && (w_occ == '0);
`else
    assign w_bypass = 1'b0;
`endif

    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            w_src[k] = w_bypass ? if_packet[k] : w_q_packet[k];
        end
    end

    // cand = min(available, rob, rs, N), then cut just after the first WFI.
    always_comb begin
        int unsigned v_cand;
        int unsigned v_cnt;
        logic        v_stop;
        v_cand    = N;
        w_wfi_hit = 1'b0;
        v_stop    = 1'b0;
        if (w_bypass) begin
            if (32'(w_in_cnt) < v_cand) v_cand = 32'(w_in_cnt);
        end else begin
            if (32'(w_occ) < v_cand) v_cand = 32'(w_occ);
        end
        if (32'(rob_spots) < v_cand) v_cand = 32'(rob_spots);
        if (32'(rs_spots) < v_cand) v_cand = 32'(rs_spots);
        if (squash || (r_state != DISP_RUN)) v_cand = 0;
        v_cnt = v_cand;
        for (int unsigned k = 0; k < N; k++) begin
            if (!v_stop && (k < v_cand) && is_wfi(w_src[k])) begin
                v_cnt     = k + 1;
                v_stop    = 1'b1;
                w_wfi_hit = 1'b1;
            end
        end
        w_disp_cnt = CNT_W'(v_cnt);
    end

    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            id_packet[k]       = w_src[k];
            id_packet[k].valid = (k < 32'(w_disp_cnt));
        end
    end

    // Bypassed lanes leave the bundle; the remainder is packed down to lane 0 for the queue.
    always_comb begin
        int unsigned v_shift;
        v_shift = w_bypass ? 32'(w_disp_cnt) : 0;
        for (int unsigned k = 0; k < N; k++) begin
            w_wr_packet[k] = '0;
            if ((k + v_shift) < N) begin
                w_wr_packet[k] = if_packet[k + v_shift];
            end
        end
    end

    assign w_deq_cnt    = w_bypass ? '0 : w_disp_cnt;
    assign w_enq_cnt    = w_accept ? (w_in_cnt - (w_bypass ? w_disp_cnt : '0)) : '0;
    assign dispatch_cnt = w_disp_cnt;
    assign occupancy    = w_occ;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= DISP_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (squash) begin
            w_state_next = DISP_RUN;
        end else if ((r_state == DISP_RUN) && w_wfi_hit) begin
            w_state_next = DISP_HALTED;
        end
    end

    always_comb begin
        halted   = 1'b0;
        if_ready = 1'b0;
        unique case (r_state)
            DISP_RUN:    if_ready = ((DEPTH - 32'(w_occ)) >= N);
            DISP_HALTED: halted   = 1'b1;
            default:     halted   = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_decode_dispatch_ctrl.sv
// Scoreboard bench for decode_dispatch_ctrl (N = 2, DEPTH = 8); expected instructions are
// queued as bundles are accepted and popped by a monitor whenever lanes dispatch.
module tb_decode_dispatch_ctrl;
    import decode_dispatch_ctrl_pkg::*;

    localparam logic [31:0] ADD = 32'h0020_81b3;
    localparam IF_ID_PACKET NONE = '0;

    logic                   clock;
    logic                   reset;
    logic                   squash;
    IF_ID_PACKET            if_packet [DISP_N];
    logic                   if_ready;
    logic [COUNT_WIDTH-1:0] rob_spots;
    logic [COUNT_WIDTH-1:0] rs_spots;
    IF_ID_PACKET            id_packet [DISP_N];
    logic [COUNT_WIDTH-1:0] dispatch_cnt;
    logic [OCC_WIDTH-1:0]   occupancy;
    logic                   halted;

    IF_ID_PACKET exp_q [$];
    int n_cmp = 0;
    int n_err = 0;

    decode_dispatch_ctrl #(
        .DEPTH (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .squash       (squash),
        .if_packet    (if_packet),
        .if_ready     (if_ready),
        .rob_spots    (rob_spots),
        .rs_spots     (rs_spots),
        .id_packet    (id_packet),
        .dispatch_cnt (dispatch_cnt),
        .occupancy    (occupancy),
        .halted       (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

    function automatic IF_ID_PACKET mk(input logic [31:0] pc, input logic [31:0] inst);
        IF_ID_PACKET p;
        p.inst  = inst;
        p.pc    = pc;
        p.npc   = pc + 32'd4;
        p.valid = 1'b1;
        return p;
    endfunction

    task automatic chk(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_bundle(input IF_ID_PACKET p0, input IF_ID_PACKET p1, input bit push);
        if_packet[0] = p0;
        if_packet[1] = p1;
        if (push) begin
            if (p0.valid) exp_q.push_back(p0);
            if (p1.valid) exp_q.push_back(p1);
        end
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && occupancy != '0; i++) step();
        chk("drain_occupancy", int'(occupancy), 0);
    endtask

    // Monitor: every dispatched lane must match the oldest outstanding expected instruction.
    always @(negedge clock) begin
        if (!reset) begin
            for (int k = 0; k < DISP_N; k++) begin
                if (k < int'(dispatch_cnt)) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_dispatch lane%0d: got pc %h expected none",
                                 k, id_packet[k].pc);
                    end else begin
                        IF_ID_PACKET e;
                        e = exp_q.pop_front();
                        n_cmp++;
                        if (id_packet[k].pc !== e.pc || id_packet[k].inst !== e.inst ||
                            id_packet[k].valid !== 1'b1) begin
                            n_err++;
                            $display("FAIL dispatch_lane%0d: got pc %h inst %h v %b expected pc %h inst %h v 1",
                                     k, id_packet[k].pc, id_packet[k].inst, id_packet[k].valid,
                                     e.pc, e.inst);
                        end
                    end
                end else if (id_packet[k].valid !== 1'b0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL idle_lane%0d_valid: got %b expected 0", k, id_packet[k].valid);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        squash    = 1'b0;
        rob_spots = 2'd2;
        rs_spots  = 2'd2;
        set_bundle(NONE, NONE, 0);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_if_ready", int'(if_ready), 1);
        chk("rst_dispatch_cnt", int'(dispatch_cnt), 0);
        chk("rst_occupancy", int'(occupancy), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_lane0_valid", int'(id_packet[0].valid), 0);
        chk("rst_lane1_valid", int'(id_packet[1].valid), 0);
        reset = 1'b0;
        step();
        step();
        chk("idle_if_ready", int'(if_ready), 1);
        chk("idle_occupancy", int'(occupancy), 0);

        // Spot limiting: rs = 1 releases one per cycle.
        rob_spots = 2'd2;
        rs_spots  = 2'd1;
`ifdef DISPATCH_BYPASS_EN
        rob_spots = 2'd0;
`endif
        set_bundle(mk(32'h100, ADD), mk(32'h104, ADD), 1);
        #1;
        chk("spot_a_cnt", int'(dispatch_cnt), 0);
        step();
        rob_spots = 2'd2;
        set_bundle(mk(32'h108, ADD), mk(32'h10c, ADD), 1);
        #1;
        chk("spot_b_occ", int'(occupancy), 2);
        chk("spot_b_cnt", int'(dispatch_cnt), 1);
        step();
        set_bundle(NONE, NONE, 0);
        #1;
        chk("spot_c_occ", int'(occupancy), 3);
        chk("spot_c_cnt", int'(dispatch_cnt), 1);
        step();
        chk("spot_d_occ", int'(occupancy), 2);
        step();
        chk("spot_e_occ", int'(occupancy), 1);
        chk("spot_e_cnt", int'(dispatch_cnt), 1);
        step();
        chk("spot_f_occ", int'(occupancy), 0);

        // Fill and backpressure with rs = 0.
        rs_spots = 2'd0;
        for (int i = 0; i < 4; i++) begin
            set_bundle(mk(32'h200 + 32'(8 * i), ADD), mk(32'h204 + 32'(8 * i), ADD), 1);
            #1;
            chk("fill_if_ready", int'(if_ready), 1);
            step();
        end
        set_bundle(mk(32'h220, ADD), mk(32'h224, ADD), 0);
        #1;
        chk("full_occ", int'(occupancy), 8);
        chk("full_if_ready", int'(if_ready), 0);
        chk("full_cnt", int'(dispatch_cnt), 0);
        step();
        set_bundle(NONE, NONE, 0);
        rs_spots = 2'd2;
        #1;
        chk("full_hold_occ", int'(occupancy), 8);
        chk("release_cnt", int'(dispatch_cnt), 2);
        step();
        chk("release_occ", int'(occupancy), 6);
        chk("release_if_ready", int'(if_ready), 1);
        drain(10);

        // Halt on WFI; younger instructions stay queued.
        rob_spots = 2'd0;
        set_bundle(mk(32'h10, ADD), mk(32'h14, WFI_INST), 1);
        step();
        set_bundle(mk(32'h18, ADD), mk(32'h1c, ADD), 1);
        #1;
        chk("halt_b_occ", int'(occupancy), 2);
        step();
        rob_spots = 2'd2;
        set_bundle(mk(32'h20, ADD), NONE, 1);
        #1;
        chk("halt_wfi_cnt", int'(dispatch_cnt), 2);
        step();
        set_bundle(mk(32'h24, ADD), mk(32'h28, ADD), 0);
        #1;
        chk("halted_flag", int'(halted), 1);
        chk("halted_if_ready", int'(if_ready), 0);
        chk("halted_cnt", int'(dispatch_cnt), 0);
        chk("halted_occ", int'(occupancy), 3);
        step();
        chk("halted_hold_occ", int'(occupancy), 3);

        // Squash while halted, then squash coincident with an incoming bundle.
        squash = 1'b1;
        set_bundle(mk(32'h30, ADD), mk(32'h34, ADD), 0);
        exp_q.delete();
        #1;
        chk("squash_cnt", int'(dispatch_cnt), 0);
        step();
        squash = 1'b0;
        set_bundle(NONE, NONE, 0);
        #1;
        chk("post_squash_occ", int'(occupancy), 0);
        chk("post_squash_halted", int'(halted), 0);
        chk("post_squash_if_ready", int'(if_ready), 1);
        rob_spots = 2'd0;
        set_bundle(mk(32'h40, ADD), mk(32'h44, ADD), 1);
        step();
        rob_spots = 2'd2;
        squash    = 1'b1;
        set_bundle(mk(32'h48, ADD), mk(32'h4c, ADD), 0);
        exp_q.delete();
        #1;
        chk("squash2_cnt", int'(dispatch_cnt), 0);
        step();
        squash = 1'b0;
        set_bundle(NONE, NONE, 0);
        #1;
        chk("squash2_occ", int'(occupancy), 0);
        step();
        step();

`ifdef DISPATCH_BYPASS_EN
        // Same-cycle bypass from empty with one ROB spot.
        rob_spots = 2'd1;
        set_bundle(mk(32'h500, ADD), mk(32'h504, ADD), 1);
        #1;
        chk("bypass_cnt", int'(dispatch_cnt), 1);
        step();
        set_bundle(NONE, NONE, 0);
        rob_spots = 2'd2;
        #1;
        chk("bypass_occ", int'(occupancy), 1);
        step();
        chk("bypass_drained", int'(occupancy), 0);
`endif

        // Streaming run long enough to wrap the pointers several times.
        rob_spots = 2'd2;
        rs_spots  = 2'd2;
        for (int i = 0; i < 20; i++) begin
            set_bundle(mk(32'h1000 + 32'(8 * i), ADD), mk(32'h1004 + 32'(8 * i), ADD), 1);
            #1;
            chk("stream_if_ready", int'(if_ready), 1);
            step();
        end
        set_bundle(NONE, NONE, 0);
        drain(10);
        step();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
